spi_ram_responder: RTL
======================

// Module: spi_ram_responder
// PURPOSE
//  SPI mode-0 slave emulating the external instruction RAM that the SPI-fetch CPU wrapper reads.
//  Decodes READ (0x03) / WRITE (0x02) commands with a 16-bit address and serves/stores bytes from an on-chip array.
//  Sits on the far end of spi_cs_n/spi_sck/spi_mosi/spi_miso; used in sim and as an on-die program store.
//  Host-side load port preloads programs while the bus is idle.
// PARAMETERS
//  AW     8   memory address width; depth = 2**AW bytes; SPI address uses addr[AW-1:0]
//  CMD_RD 8'h03  read opcode
//  CMD_WR 8'h02  write opcode
// PORTS
//  clk        in   1   system clock; must be >= 8x f_sck
//  rst_n      in   1   synchronous, active-low reset
//  spi_cs_n   in   1   chip select, active low (async to clk)
//  spi_sck    in   1   serial clock, idle low (async to clk)
//  spi_mosi   in   1   master out, MSB first, sampled on SCK rise
//  spi_miso   out  1   slave out, MSB first, changes after SCK fall
//  load_en    in   1   host write strobe; honoured only when busy==0
//  load_addr  in   AW  host write address
//  load_data  in   8   host write data
//  busy       out  1   transaction in progress (CS low, synced)
//  err        out  1   unsupported opcode seen; sticky until next CS fall
// BEHAVIOUR
//  Reset: spi_miso=0, busy=0, err=0, state=IDLE, shift regs/bit counter=0. Memory NOT cleared.
//  Inputs cs_n/sck/mosi pass 2-FF synchronisers; sck rise/fall and cs fall/rise detected on synced values.
//  Frame: CS fall -> 8b opcode -> 8b addr_hi -> 8b addr_lo -> data bytes until CS rise.
//  States: IDLE -> CMD (on cs fall, err cleared) -> ADDR_HI -> ADDR_LO -> RD_DATA | WR_DATA;
//   CMD with unknown opcode -> IGNORE (err=1, miso held 0). Any state -> IDLE on cs rise.
//  Bit counter 3b; byte completes on 8th synced SCK rise; counter wraps to 0.
//  RD_DATA: mem[addr] read in the clk after addr_lo completes; shift reg loaded so bit7 is on
//   spi_miso within 3 clk of the next SCK fall (before 25th rise). Next byte preloaded at each
//   byte boundary; addr increments per byte, wraps modulo 2**AW.
//  WR_DATA: on 8th rise of each data byte, mem[addr]<=byte 1 clk later; addr++ (wrap).
//  Address bits above AW ignored (aliased).
//  CS rise mid-byte: partial byte discarded, no write, spi_miso->0 within 3 clk.
//  CS low while rst_n low: ignored; after reset, responder waits for a fresh CS fall.
//  load_en while busy=1: dropped (no write). SPI write always wins; no same-cycle conflict possible.
//  spi_miso=0 whenever state not RD_DATA.
// STRUCTURE
//  Shared include spi_defs.vh: CMD_RD/CMD_WR defaults, state encodings (3b), shared with spi_read_byte tests.
//  Sub-module spi_sync_edge: 2-FF sync + rise/fall pulse for one input, instanced for cs_n, sck; mosi uses plain sync.
//  Memory: reg [7:0] mem [0:2**AW-1], single write port (SPI or load mux), registered read.
// TESTING
//  Preload mem[0x10]=0xA5 via load port; READ 0x03,0x00,0x10, 1 byte -> MISO returns 0xA5, err=0.
//  READ from 0x00FF, 3 bytes, AW=8, mem[FF,00,01]=11,22,33 -> 0x11,0x22,0x33 (wrap).
//  WRITE 0x02,0x00,0x20, bytes 0xDE,0xAD, CS high -> READ 0x20 two bytes returns 0xDE,0xAD.
//  WRITE to 0x30 then CS rise after 5 data bits -> mem[0x30] unchanged; busy=0 within 3 clk.
//  Opcode 0x9F -> err=1, MISO stays 0; next CS fall with valid READ clears err and reads correctly.
//  load_en to 0x40 while busy=1 -> mem[0x40] unchanged; rst_n low mid-READ -> miso=0, busy=0, mem intact.

Source files
------------

// File: rtl/spi_ram_responder_pkg.sv
// Shared definitions for the SPI RAM responder.
//   - Default READ / WRITE opcodes.
//   - Protocol FSM state encoding (3 bits).
package spi_ram_responder_pkg;

    localparam logic [7:0] CMD_RD_DEFAULT = 8'h03;
    localparam logic [7:0] CMD_WR_DEFAULT = 8'h02;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCmd    = 3'd1,
        StAddrHi = 3'd2,
        StAddrLo = 3'd3,
        StRdData = 3'd4,
        StWrData = 3'd5,
        StIgnore = 3'd6
    } state_e;

endpackage

// File: rtl/spi_ram_responder_sync_edge.sv
// Two-flop synchroniser plus single-cycle edge pulses for one asynchronous input.
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   async_i      asynchronous input pin
//   rise_o       one clk pulse on a synchronised 0->1 transition
//   fall_o       one clk pulse on a synchronised 1->0 transition
// ResetVal sets what the chain believes the pin was before reset released.
module spi_ram_responder_sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
            prev_q <= ResetVal;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 slave that emulates an external byte-wide instruction RAM.
// Frame: CS fall, opcode, addr_hi, addr_lo, then data bytes until CS rise.
// READ streams mem[addr], mem[addr+1], ...; WRITE stores each completed byte.
// Ports:
//   clk, rst_n                 system clock (>= 8x SCK), synchronous active-low reset
//   spi_cs_n/spi_sck/spi_mosi  asynchronous SPI inputs
//   spi_miso                   serial read data, updated after SCK fall, 0 outside read data
//   load_en/load_addr/load_data host preload port, ignored while busy
//   busy                       frame in progress
//   err                        unsupported opcode seen, cleared on the next CS fall
module spi_ram_responder
    import spi_ram_responder_pkg::*;
#(
    parameter int unsigned AW     = 8,
    parameter logic [7:0]  CMD_RD = CMD_RD_DEFAULT,
    parameter logic [7:0]  CMD_WR = CMD_WR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_cs_n,
    input  logic          spi_sck,
    input  logic          spi_mosi,
    output logic          spi_miso,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic          busy,
    output logic          err
);

    logic cs_rise, cs_fall, sck_rise, sck_fall;

    // CS chain resets to "low" so a CS already held low at reset release
    // produces no fall pulse; the responder waits for a fresh frame.
    spi_ram_responder_sync_edge #(
        .ResetVal (1'b0)
    ) u_sync_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_cs_n),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_ram_responder_sync_edge #(
        .ResetVal (1'b0)
    ) u_sync_sck (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_sck),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    logic mosi_meta_q, mosi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            mosi_meta_q <= spi_mosi;
            mosi_q      <= mosi_meta_q;
        end
    end

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shift_in_q, shift_in_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    shift_out_q, shift_out_d;
    logic          op_rd_q, op_rd_d;
    logic          fetch_q, fetch_d;
    logic          wr_pend_q, wr_pend_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          miso_q, miso_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [7:0]    rd_data_q;
    logic [7:0]    in_byte;
    logic          byte_done;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        addr_d      = addr_q;
        shift_out_d = shift_out_q;
        op_rd_d     = op_rd_q;
        fetch_d     = 1'b0;
        wr_pend_d   = 1'b0;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        in_byte     = {shift_in_q, mosi_q};
        byte_done   = sck_rise && (state_q != StIdle) && (bit_cnt_q == 3'd7);

        if (sck_rise && (state_q != StIdle)) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            shift_in_d = in_byte[6:0];
        end

        // Post-increment after each fetch or committed write.
        if (fetch_q || wr_pend_q) begin
            addr_d = addr_q + AW'(1);
        end

        unique case (state_q)
            StIdle: ;
            StCmd: begin
                if (byte_done) begin
                    if (in_byte == CMD_RD || in_byte == CMD_WR) begin
                        op_rd_d = (in_byte == CMD_RD);
                        state_d = StAddrHi;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIgnore;
                    end
                end
            end
            StAddrHi: begin
                if (byte_done) begin
                    addr_d  = AW'({addr_q, in_byte});
                    state_d = StAddrLo;
                end
            end
            StAddrLo: begin
                if (byte_done) begin
                    // Upper address bits fall off the truncation, aliasing the array.
                    addr_d = AW'({addr_q, in_byte});
                    if (op_rd_q) begin
                        fetch_d = 1'b1;
                        state_d = StRdData;
                    end else begin
                        state_d = StWrData;
                    end
                end
            end
            StRdData: begin
                if (sck_fall) begin
                    // Counter at 0 on a fall means a byte boundary: present the
                    // prefetched byte and start fetching the one after it.
                    if (bit_cnt_q == 3'd0) begin
                        shift_out_d = rd_data_q;
                        fetch_d     = 1'b1;
                    end else begin
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                    end
                end
            end
            StWrData: begin
                if (byte_done) begin
                    wr_pend_d = 1'b1;
                    wr_data_d = in_byte;
                end
            end
            StIgnore: ;
            default: state_d = StIdle;
        endcase

        if (cs_fall) begin
            state_d     = StCmd;
            bit_cnt_d   = 3'd0;
            shift_in_d  = 7'd0;
            shift_out_d = 8'd0;
            err_d       = 1'b0;
        end else if (cs_rise) begin
            // A partially shifted byte is simply dropped here.
            state_d    = StIdle;
            bit_cnt_d  = 3'd0;
            shift_in_d = 7'd0;
        end

        miso_d = (state_d == StRdData) ? shift_out_d[7] : 1'b0;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 7'd0;
            addr_q      <= '0;
            shift_out_q <= 8'd0;
            op_rd_q     <= 1'b0;
            fetch_q     <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_data_q   <= 8'd0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            addr_q      <= addr_d;
            shift_out_q <= shift_out_d;
            op_rd_q     <= op_rd_d;
            fetch_q     <= fetch_d;
            wr_pend_q   <= wr_pend_d;
            wr_data_q   <= wr_data_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Single write port: a committed SPI byte takes priority over the host port.
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_q [2**AW];

    always_comb begin
        mem_we    = wr_pend_q | (load_en & ~busy_q);
        mem_waddr = wr_pend_q ? addr_q : load_addr;
        mem_wdata = wr_pend_q ? wr_data_q : load_data;
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        if (fetch_q) begin
            rd_data_q <= mem_q[addr_q];
        end
    end

    assign spi_miso = miso_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
